// File: rtl/mux4_4b_arbiter_pkg.sv
// Shared types and sizing constants for the 4-requester, 4-bit output arbiter.
package mux4_4b_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 4;

  typedef logic [1:0] req_id_t;

endpackage

// File: rtl/mux4_4b_arbiter_if.sv
// Handshake bundle between four producers, the arbiter and its single consumer.
interface mux4_4b_arbiter_if;
  import mux4_4b_arbiter_pkg::*;

  logic [NUM_REQ-1:0] in_val;
  logic [NUM_REQ-1:0] in_rdy;
  logic [DATA_W-1:0]  in0_data;
  logic [DATA_W-1:0]  in1_data;
  logic [DATA_W-1:0]  in2_data;
  logic [DATA_W-1:0]  in3_data;
  logic               out_val;
  logic               out_rdy;
  logic [DATA_W-1:0]  out_data;
  req_id_t            out_id;

  modport master (
    output in_val, in0_data, in1_data, in2_data, in3_data, out_rdy,
    input  in_rdy, out_val, out_data, out_id
  );

  modport slave (
    input  in_val, in0_data, in1_data, in2_data, in3_data, out_rdy,
    output in_rdy, out_val, out_data, out_id
  );

endinterface

// File: rtl/mux4_4b_arbiter_mux.sv
// Four-way 4-bit data selector feeding the arbiter's output buffer.
module Mux4_4b_RTL
  import mux4_4b_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  req_id_t           sel,
  output logic [DATA_W-1:0] out
);

  always_comb begin
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end

endmodule

// File: rtl/mux4_4b_arbiter.sv
// Four-requester arbiter with a one-entry registered output buffer.
// Define MUX4_4B_ARBITER_ROUND_ROBIN_EN for round-robin; otherwise fixed priority (0 highest).
module mux4_4b_arbiter
  import mux4_4b_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mux4_4b_arbiter_if.slave   bus
);

  logic              full;
  logic [DATA_W-1:0] buf_data;
  req_id_t           buf_id;
  req_id_t           ptr;
  req_id_t           win;
  req_id_t           idx;
  logic              any_val;
  logic              can_acc;
  logic [NUM_REQ-1:0] rdy;
  logic              xfer_in;
  logic              xfer_out;
  logic [DATA_W-1:0] mux_out;

  // Scan from the far end back toward ptr so the last hit is the nearest one.
  always_comb begin
    win     = ptr;
    any_val = 1'b0;
    idx     = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + k[1:0];
      if (bus.in_val[idx]) begin
        win     = idx;
        any_val = 1'b1;
      end
    end
    can_acc = !full || bus.out_rdy;
    rdy     = '0;
    if (any_val && can_acc && rst_n)
      rdy[win] = 1'b1;
  end

  assign xfer_in  = |rdy;
  assign xfer_out = full && bus.out_rdy;

  Mux4_4b_RTL u_mux (
    .in0 (bus.in0_data),
    .in1 (bus.in1_data),
    .in2 (bus.in2_data),
    .in3 (bus.in3_data),
    .sel (win),
    .out (mux_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      buf_data <= '0;
      buf_id   <= '0;
    end else if (xfer_in) begin
      full     <= 1'b1;
      buf_data <= mux_out;
      buf_id   <= win;
    end else if (xfer_out) begin
      full     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else begin
`ifdef MUX4_4B_ARBITER_ROUND_ROBIN_EN
      if (xfer_in)
        ptr <= win + 2'd1;
`else
      ptr <= '0;
`endif
    end
  end

  assign bus.in_rdy   = rdy;
  assign bus.out_val  = full;
  assign bus.out_data = buf_data;
  assign bus.out_id   = buf_id;

endmodule

// File: tb/tb_mux4_4b_arbiter.sv
// Directed, table-driven bench for mux4_4b_arbiter (either arbitration build).
module tb_mux4_4b_arbiter;
  import mux4_4b_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  mux4_4b_arbiter_if bus ();

  mux4_4b_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] val;
    logic [3:0] d0, d1, d2, d3;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_oval;
    logic [3:0] exp_odata;
    logic [1:0] exp_oid;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] val, input logic [3:0] d0, input logic [3:0] d1,
                       input logic [3:0] d2, input logic [3:0] d3, input logic ordy);
    bus.in_val   = val;
    bus.in0_data = d0;
    bus.in1_data = d1;
    bus.in2_data = d2;
    bus.in3_data = d3;
    bus.out_rdy  = ordy;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] id);
    chk({tag, ".out_val"},  {7'd0, bus.out_val}, {7'd0, v});
    chk({tag, ".out_data"}, {4'd0, bus.out_data}, {4'd0, d});
    chk({tag, ".out_id"},   {6'd0, bus.out_id},  {6'd0, id});
  endtask

  task automatic add(input logic [3:0] val, input logic [3:0] d0, input logic [3:0] d1,
                     input logic [3:0] d2, input logic [3:0] d3, input logic ordy,
                     input logic [3:0] er, input logic ev, input logic [3:0] ed, input logic [1:0] ei);
    vec_t v;
    v.val = val; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.ordy = ordy;
    v.exp_rdy = er; v.exp_oval = ev; v.exp_odata = ed; v.exp_oid = ei;
    vecs.push_back(v);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

`ifdef MUX4_4B_ARBITER_ROUND_ROBIN_EN
    add(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0);
    add(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1);
    add(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2);
    add(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3);
    add(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0);
    add(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1);
`else
    for (int i = 0; i < 6; i++)
      add(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0);
`endif
    add(4'b0100, 4'h0, 4'h0, 4'hA, 4'h0, 1'b1, 4'b0100, 1'b1, 4'hA, 2'd2);
    add(4'b0000, 4'h0, 4'h0, 4'hA, 4'h0, 1'b1, 4'b0000, 1'b0, 4'hA, 2'd2);
    add(4'b0010, 4'h6, 4'h7, 4'h0, 4'h0, 1'b1, 4'b0010, 1'b1, 4'h7, 2'd1);
`ifdef MUX4_4B_ARBITER_ROUND_ROBIN_EN
    add(4'b0011, 4'h6, 4'h7, 4'h0, 4'h0, 1'b1, 4'b0001, 1'b1, 4'h6, 2'd0);
    add(4'b0011, 4'h6, 4'h7, 4'h0, 4'h0, 1'b1, 4'b0010, 1'b1, 4'h7, 2'd1);
`else
    add(4'b0011, 4'h6, 4'h7, 4'h0, 4'h0, 1'b1, 4'b0001, 1'b1, 4'h6, 2'd0);
    add(4'b0011, 4'h6, 4'h7, 4'h0, 4'h0, 1'b1, 4'b0001, 1'b1, 4'h6, 2'd0);
`endif
    add(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 4'h7 ^ 4'h0, 2'd0);
`ifdef MUX4_4B_ARBITER_ROUND_ROBIN_EN
    vecs[vecs.size()-1].exp_odata = 4'h7;
    vecs[vecs.size()-1].exp_oid   = 2'd1;
`else
    vecs[vecs.size()-1].exp_odata = 4'h6;
    vecs[vecs.size()-1].exp_oid   = 2'd0;
`endif

    // Reset held with every requester active.
    rst_n = 1'b0;
    drive(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    #3;
    chk("rst.in_rdy", {4'd0, bus.in_rdy}, 8'h00);
    chk_out("rst", 1'b0, 4'h0, 2'd0);
    @(posedge clk); #1;
    chk("rst_hold.in_rdy", {4'd0, bus.in_rdy}, 8'h00);
    chk_out("rst_hold", 1'b0, 4'h0, 2'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].val, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].ordy);
      #1;
      chk($sformatf("vec%0d.in_rdy", i), {4'd0, bus.in_rdy}, {4'd0, vecs[i].exp_rdy});
      @(posedge clk); #1;
      chk_out($sformatf("vec%0d", i), vecs[i].exp_oval, vecs[i].exp_odata, vecs[i].exp_oid);
    end

    // Backpressure: fill with 5, stall three cycles, then release.
    drive(4'b0001, 4'h5, 4'h9, 4'h0, 4'h0, 1'b0);
    #1;
    chk("bp_fill.in_rdy", {4'd0, bus.in_rdy}, 8'h01);
    @(posedge clk); #1;
    chk_out("bp_fill", 1'b1, 4'h5, 2'd0);
    drive(4'b0010, 4'h5, 4'h9, 4'h0, 4'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_stall%0d.in_rdy", c), {4'd0, bus.in_rdy}, 8'h00);
      @(posedge clk); #1;
      chk_out($sformatf("bp_stall%0d", c), 1'b1, 4'h5, 2'd0);
    end
    bus.out_rdy = 1'b1;
    #1;
    chk("bp_release.in_rdy", {4'd0, bus.in_rdy}, 8'h02);
    @(posedge clk); #1;
    chk_out("bp_release", 1'b1, 4'h9, 2'd1);
    drive(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    @(posedge clk); #1;
    chk("bp_drain.out_val", {7'd0, bus.out_val}, 8'h00);

    // Mid-transfer reset while holding a word from requester 3.
    drive(4'b1000, 4'h0, 4'h0, 4'h0, 4'hC, 1'b0);
    @(posedge clk); #1;
    chk_out("mrst_fill", 1'b1, 4'hC, 2'd3);
    drive(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("mrst_async", 1'b0, 4'h0, 2'd0);
    chk("mrst_async.in_rdy", {4'd0, bus.in_rdy}, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_rdy = 1'b1;
    @(posedge clk); #1;
    chk_out("mrst_after", 1'b0, 4'h0, 2'd0);
    drive(4'b1010, 4'h0, 4'h3, 4'h0, 4'hE, 1'b1);
    #1;
    chk("mrst_grant.in_rdy", {4'd0, bus.in_rdy}, 8'h02);
    @(posedge clk); #1;
    chk_out("mrst_grant", 1'b1, 4'h3, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
